// File: rtl/evm_monitor_if.sv
// Demodulated-symbol stream feeding the EVM monitor.
//   demod_i / demod_q : signed I/Q sample of one symbol
//   demod_valid       : one-cycle symbol strobe
//   demod_lock        : carrier-recovery lock indicator
// master drives the stream (rx_top side), slave consumes it (evm_monitor).
interface evm_monitor_if #(
  parameter int unsigned DATA_W = 16
) ();
  logic signed [DATA_W-1:0] demod_i;
  logic signed [DATA_W-1:0] demod_q;
  logic                     demod_valid;
  logic                     demod_lock;

  modport master (output demod_i, output demod_q, output demod_valid, output demod_lock);
  modport slave  (input  demod_i, input  demod_q, input  demod_valid, input  demod_lock);
endinterface

// File: rtl/evm_monitor.sv
// 16-QAM link-quality monitor.
// Slices each locked symbol to the nearest ideal point (Gray-coded hard decision), accumulates
// clamped squared error-vector magnitude over windows of 2^WIN_LOG2 symbols and publishes the
// window mean plus a 2-bit quality grade.
//   clk_dsp, sys_rst_n : clock, asynchronous active-low reset
//   clr_i              : synchronous window restart (flush without abort report)
//   demod_if           : symbol stream (slave modport)
//   sym_idx_o          : hard decision {gI, gQ}, qualified by sym_idx_valid_o
//   evm_mean_o         : last completed window mean of e_I^2 + e_Q^2, strobed by evm_valid_o
//   quality_o          : 3 good, 2 fair, 1 poor, 0 bad/unknown
//   win_abort_o        : pulse when a partial window is discarded on lock loss
module evm_monitor #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned LVL_LOG2 = 11,
  parameter int unsigned WIN_LOG2 = 10,
  parameter int unsigned MEAN_W   = 2 * LVL_LOG2 + 3,
  parameter int unsigned TH_GOOD  = 40000,
  parameter int unsigned TH_FAIR  = 160000,
  parameter int unsigned TH_POOR  = 640000
) (
  input  logic                clk_dsp,
  input  logic                sys_rst_n,
  input  logic                clr_i,
  evm_monitor_if.slave        demod_if,
  output logic [3:0]          sym_idx_o,
  output logic                sym_idx_valid_o,
  output logic [MEAN_W-1:0]   evm_mean_o,
  output logic                evm_valid_o,
  output logic [1:0]          quality_o,
  output logic                win_abort_o
);

  localparam int unsigned ExtW = DATA_W + 2;    // room for x - ideal without wrap
  localparam int unsigned ErrW = LVL_LOG2 + 2;  // clamped error +-(2*LVL-1)
  localparam int unsigned PrdW = 2 * ErrW;
  localparam int unsigned AccW = MEAN_W + WIN_LOG2;

  localparam logic signed [ExtW-1:0] Lvl1   = ExtW'(2 ** LVL_LOG2);
  localparam logic signed [ExtW-1:0] Lvl2   = ExtW'(2 ** (LVL_LOG2 + 1));
  localparam logic signed [ExtW-1:0] Lvl3   = ExtW'(3 * (2 ** LVL_LOG2));
  localparam logic signed [ExtW-1:0] ErrMax = ExtW'(2 ** (LVL_LOG2 + 1) - 1);

  typedef enum logic [0:0] {StIdle, StAcc} state_e;

  // Returns {gray[1:0], clamped error}; boundary ties resolve to the upper point.
  function automatic logic [ErrW+1:0] slice_axis(input logic signed [DATA_W-1:0] x);
    logic signed [ExtW-1:0] xe;
    logic signed [ExtW-1:0] ideal;
    logic signed [ExtW-1:0] e;
    logic [1:0]             gray;
    xe = {{(ExtW - DATA_W){x[DATA_W-1]}}, x};
    if (xe < -Lvl2) begin
      ideal = -Lvl3;
      gray  = 2'b00;
    end else if (xe[ExtW-1]) begin
      ideal = -Lvl1;
      gray  = 2'b01;
    end else if (xe < Lvl2) begin
      ideal = Lvl1;
      gray  = 2'b11;
    end else begin
      ideal = Lvl3;
      gray  = 2'b10;
    end
    e = xe - ideal;
    if (e > ErrMax) begin
      e = ErrMax;
    end else if (e < -ErrMax) begin
      e = -ErrMax;
    end
    return {gray, e[ErrW-1:0]};
  endfunction

  function automatic logic [1:0] grade(input logic [MEAN_W-1:0] m);
    if (m < MEAN_W'(TH_GOOD)) return 2'd3;
    if (m < MEAN_W'(TH_FAIR)) return 2'd2;
    if (m < MEAN_W'(TH_POOR)) return 2'd1;
    return 2'd0;
  endfunction

  state_e state_q, state_d;

  logic                   s1_vld_q, s1_vld_d;
  logic [3:0]             sym_q, sym_d;
  logic signed [ErrW-1:0] ei_q, ei_d, eq_q, eq_d;
  logic                   s2_vld_q, s2_vld_d;
  logic [MEAN_W-1:0]      sq_q, sq_d;
  logic [AccW-1:0]        acc_q, acc_d;
  logic [WIN_LOG2-1:0]    cnt_q, cnt_d;
  logic [MEAN_W-1:0]      mean_q, mean_d;
  logic [1:0]             qual_q, qual_d;
  logic                   evm_vld_q, evm_vld_d;
  logic                   abort_q, abort_d;

  logic                   lock;
  logic                   accept;
  logic                   flush;
  logic [ErrW+1:0]        slc_i, slc_q;
  logic signed [PrdW-1:0] ei_w, eq_w, prod_i, prod_q;
  logic [AccW-1:0]        acc_sum;
  logic [MEAN_W-1:0]      mean_new;

  assign lock   = demod_if.demod_lock;
  assign accept = demod_if.demod_valid && lock && !clr_i;
  // Lock loss and clr both discard the window and every in-flight contribution.
  assign flush  = clr_i || !lock;

  assign slc_i = slice_axis(demod_if.demod_i);
  assign slc_q = slice_axis(demod_if.demod_q);

  assign ei_w   = PrdW'(ei_q);
  assign eq_w   = PrdW'(eq_q);
  assign prod_i = ei_w * ei_w;
  assign prod_q = eq_w * eq_w;

  assign acc_sum  = acc_q + AccW'(sq_q);
  assign mean_new = MEAN_W'(acc_sum >> WIN_LOG2);

  // FSM: state register
  always_ff @(posedge clk_dsp or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (lock) state_d = StAcc;
      StAcc:   if (!lock) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: output -- abort is reported only if something was actually discarded
  always_comb begin
    abort_d = 1'b0;
    if (state_q == StAcc && !lock) begin
      abort_d = (cnt_q != '0) || s1_vld_q || s2_vld_q;
    end
  end

  // Datapath next state
  always_comb begin
    s1_vld_d = accept;
    sym_d    = sym_q;
    ei_d     = ei_q;
    eq_d     = eq_q;
    if (accept) begin
      sym_d = {slc_i[ErrW+1:ErrW], slc_q[ErrW+1:ErrW]};
      ei_d  = slc_i[ErrW-1:0];
      eq_d  = slc_q[ErrW-1:0];
    end

    s2_vld_d = s1_vld_q && !flush;
    sq_d     = sq_q;
    if (s1_vld_q) begin
      sq_d = MEAN_W'($unsigned(prod_i)) + MEAN_W'($unsigned(prod_q));
    end

    acc_d     = acc_q;
    cnt_d     = cnt_q;
    mean_d    = mean_q;
    qual_d    = qual_q;
    evm_vld_d = 1'b0;
    if (flush) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (s2_vld_q) begin
      if (cnt_q == '1) begin
        acc_d     = '0;
        cnt_d     = '0;
        mean_d    = mean_new;
        qual_d    = grade(mean_new);
        evm_vld_d = 1'b1;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_dsp or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_vld_q  <= 1'b0;
      sym_q     <= '0;
      ei_q      <= '0;
      eq_q      <= '0;
      s2_vld_q  <= 1'b0;
      sq_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      mean_q    <= '0;
      qual_q    <= '0;
      evm_vld_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      sym_q     <= sym_d;
      ei_q      <= ei_d;
      eq_q      <= eq_d;
      s2_vld_q  <= s2_vld_d;
      sq_q      <= sq_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      mean_q    <= mean_d;
      qual_q    <= qual_d;
      evm_vld_q <= evm_vld_d;
      abort_q   <= abort_d;
    end
  end

  assign sym_idx_o       = sym_q;
  assign sym_idx_valid_o = s1_vld_q;
  assign evm_mean_o      = mean_q;
  assign evm_valid_o     = evm_vld_q;
  assign quality_o       = qual_q;
  assign win_abort_o     = abort_q;

endmodule

// File: tb/tb_evm_monitor.sv
// Randomized self-checking bench for evm_monitor (16-symbol windows).
// The reference model works on whole symbols: nearest-level arithmetic, a queue of pending
// squared errors with their due cycle, and a running window sum.
module tb_evm_monitor;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned LVL_LOG2 = 11;
  localparam int unsigned WIN_LOG2 = 4;
  localparam int unsigned MEAN_W   = 2 * LVL_LOG2 + 3;
  localparam int          Lvl      = 2048;
  localparam int          WinLen   = 16;

  logic              clk_dsp = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              clr = 1'b0;
  logic [3:0]        sym_idx;
  logic              sym_idx_valid;
  logic [MEAN_W-1:0] evm_mean;
  logic              evm_valid;
  logic [1:0]        quality;
  logic              win_abort;

  evm_monitor_if #(.DATA_W(DATA_W)) demod_if ();

  evm_monitor #(
    .DATA_W   (DATA_W),
    .LVL_LOG2 (LVL_LOG2),
    .WIN_LOG2 (WIN_LOG2),
    .MEAN_W   (MEAN_W)
  ) dut (
    .clk_dsp         (clk_dsp),
    .sys_rst_n       (sys_rst_n),
    .clr_i           (clr),
    .demod_if        (demod_if),
    .sym_idx_o       (sym_idx),
    .sym_idx_valid_o (sym_idx_valid),
    .evm_mean_o      (evm_mean),
    .evm_valid_o     (evm_valid),
    .quality_o       (quality),
    .win_abort_o     (win_abort)
  );

  always #5 clk_dsp = ~clk_dsp;

  int n_checks = 0;
  int n_errors = 0;
  int n_evm_seen = 0;
  int n_abort_seen = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int     add_at;
    longint sq;
  } pend_t;

  pend_t  pend_q[$];
  int     now = 0;
  int     m_cnt = 0;
  longint m_sum = 0;
  bit     m_locked = 1'b0;
  logic [3:0] e_sym = 4'h0;
  bit     e_sym_vld = 1'b0;
  bit     e_evm_vld = 1'b0;
  bit     e_abort = 1'b0;
  longint e_mean = 0;
  int     e_qual = 0;

  // Nearest ideal level in units of Lvl: one of -3, -1, +1, +3.
  function automatic int level_of(int x);
    int k;
    k = (x >= 0) ? x / (2 * Lvl) : -((-x + 2 * Lvl - 1) / (2 * Lvl));
    if (k > 1) k = 1;
    if (k < -2) k = -2;
    return 2 * k + 1;
  endfunction

  function automatic logic [1:0] gray_of(int lvl);
    case (lvl)
      -3:      return 2'b00;
      -1:      return 2'b01;
      1:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic longint err_sq(int x);
    int e;
    e = x - level_of(x) * Lvl;
    if (e > 2 * Lvl - 1) e = 2 * Lvl - 1;
    if (e < -(2 * Lvl - 1)) e = -(2 * Lvl - 1);
    return longint'(e) * longint'(e);
  endfunction

  function automatic int grade(longint m);
    if (m < 40000) return 3;
    if (m < 160000) return 2;
    if (m < 640000) return 1;
    return 0;
  endfunction

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input bit v, input int xi, input int xq, input bit lk, input bit cl);
    pend_t p;
    now++;
    e_sym_vld = 1'b0;
    e_evm_vld = 1'b0;
    e_abort   = 1'b0;
    if (cl || !lk) begin
      if (m_locked && !lk && (m_cnt != 0 || pend_q.size() != 0)) e_abort = 1'b1;
      pend_q.delete();
      m_cnt = 0;
      m_sum = 0;
    end else if (pend_q.size() != 0 && pend_q[0].add_at == now) begin
      p = pend_q.pop_front();
      m_sum += p.sq;
      m_cnt++;
      if (m_cnt == WinLen) begin
        e_evm_vld = 1'b1;
        e_mean    = m_sum / WinLen;
        e_qual    = grade(e_mean);
        m_cnt     = 0;
        m_sum     = 0;
      end
    end
    if (v && lk && !cl) begin
      e_sym     = {gray_of(level_of(xi)), gray_of(level_of(xq))};
      e_sym_vld = 1'b1;
      p.add_at  = now + 2;
      p.sq      = err_sq(xi) + err_sq(xq);
      pend_q.push_back(p);
    end
    m_locked = lk;
  endtask

  task automatic model_reset();
    pend_q.delete();
    m_cnt = 0; m_sum = 0; m_locked = 1'b0;
    e_sym = 4'h0; e_sym_vld = 1'b0; e_evm_vld = 1'b0; e_abort = 1'b0;
    e_mean = 0; e_qual = 0;
  endtask

  task automatic compare_all();
    if (evm_valid) n_evm_seen++;
    if (win_abort) n_abort_seen++;
    check_eq("sym_idx", sym_idx, e_sym);
    check_eq("sym_idx_valid", sym_idx_valid, e_sym_vld);
    check_eq("evm_valid", evm_valid, e_evm_vld);
    check_eq("evm_mean", evm_mean, e_mean);
    check_eq("quality", quality, e_qual);
    check_eq("win_abort", win_abort, e_abort);
  endtask

  task automatic set_inputs(input bit v, input int xi, input int xq, input bit lk, input bit cl);
    demod_if.demod_valid = v;
    demod_if.demod_i     = 16'(xi);
    demod_if.demod_q     = 16'(xq);
    demod_if.demod_lock  = lk;
    clr                  = cl;
  endtask

  task automatic drive(input bit v, input int xi, input int xq, input bit lk, input bit cl);
    @(negedge clk_dsp);
    set_inputs(v, xi, xq, lk, cl);
    model_step(v, xi, xq, lk, cl);
    @(posedge clk_dsp);
    #1;
    compare_all();
  endtask

  task automatic burst(input int n, input int xi, input int xq);
    for (int k = 0; k < n; k++) drive(1'b1, xi, xq, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 1'b1, 1'b0);
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge.
  task automatic async_reset();
    @(negedge clk_dsp);
    #2;
    set_inputs(1'b0, 0, 0, 1'b0, 1'b0);
    sys_rst_n = 1'b0;
    #1;
    check_eq("rst_sym_idx", sym_idx, 0);
    check_eq("rst_sym_idx_valid", sym_idx_valid, 0);
    check_eq("rst_evm_mean", evm_mean, 0);
    check_eq("rst_evm_valid", evm_valid, 0);
    check_eq("rst_quality", quality, 0);
    check_eq("rst_win_abort", win_abort, 0);
    model_reset();
    #1;
    sys_rst_n = 1'b1;
    model_step(1'b0, 0, 0, 1'b0, 1'b0);
    @(posedge clk_dsp);
    #1;
    compare_all();
  endtask

  function automatic int rand_axis();
    int lv;
    int amp;
    lv = 2 * int'($urandom_range(0, 3)) - 3;
    case ($urandom_range(0, 3))
      0:       amp = 150;
      1:       amp = 400;
      2:       amp = 1200;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
    return lv * Lvl + int'($urandom_range(0, 2 * amp)) - amp;
  endfunction

  int bnd_x[6]   = '{4096, 4095, 0, -1, -4096, -4097};
  int bnd_g[6]   = '{2, 3, 3, 1, 1, 0};
  int evm_mark;
  int abort_mark;
  int lock_off;

  initial begin
    set_inputs(1'b0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clk_dsp);
    async_reset();

    // Ideal point
    evm_mark = n_evm_seen;
    burst(WinLen, 2048, -6144);
    check_eq("ideal_sym", sym_idx, 4'hC);
    idle(4);
    check_eq("ideal_windows", n_evm_seen - evm_mark, 1);
    check_eq("ideal_mean", evm_mean, 0);
    check_eq("ideal_quality", quality, 3);

    // Small offset
    burst(WinLen, 2148, 2048);
    check_eq("offset_sym", sym_idx, 4'hF);
    idle(4);
    check_eq("offset_mean", evm_mean, 10000);
    check_eq("offset_quality", quality, 3);

    // Clamp path
    burst(WinLen, 32767, 0);
    check_eq("clamp_sym", sym_idx, 4'hB);
    idle(4);
    check_eq("clamp_mean", evm_mean, 20963329);
    check_eq("clamp_quality", quality, 0);

    // Slicer boundaries (leaves 6 symbols in the open window)
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, bnd_x[k], 2048, 1'b1, 1'b0);
      check_eq("boundary_gi", sym_idx[3:2], bnd_g[k]);
    end

    // Lock loss mid-window
    evm_mark   = n_evm_seen;
    abort_mark = n_abort_seen;
    burst(7, 2048, 2048);
    for (int k = 0; k < 4; k++) drive(1'b1, 2048, 2048, 1'b0, 1'b0);
    check_eq("lockloss_aborts", n_abort_seen - abort_mark, 1);
    check_eq("lockloss_windows", n_evm_seen - evm_mark, 0);
    check_eq("lockloss_mean_held", evm_mean, 20963329);
    check_eq("lockloss_quality_held", quality, 0);
    burst(WinLen, 2248, 2048);
    idle(4);
    check_eq("relock_mean", evm_mean, 40000);
    check_eq("relock_quality", quality, 2);

    // clr on the cycle the 16th sample is added
    evm_mark   = n_evm_seen;
    abort_mark = n_abort_seen;
    burst(WinLen, 2148, 2048);
    idle(1);
    drive(1'b0, 0, 0, 1'b1, 1'b1);
    idle(4);
    check_eq("clr_windows", n_evm_seen - evm_mark, 0);
    check_eq("clr_aborts", n_abort_seen - abort_mark, 0);
    check_eq("clr_mean_held", evm_mean, 40000);
    burst(WinLen, 2048, 2048);
    idle(4);
    check_eq("clr_restart_windows", n_evm_seen - evm_mark, 1);
    check_eq("clr_restart_mean", evm_mean, 0);

    // Reset mid-window
    burst(5, 2148, 2048);
    async_reset();
    burst(WinLen, 2148, 2048);
    idle(4);
    check_eq("post_reset_mean", evm_mean, 10000);
    check_eq("post_reset_quality", quality, 3);

    // Randomized traffic with gaps, lock drops and clr
    lock_off = 0;
    for (int c = 0; c < 3000; c++) begin
      bit v;
      bit lk;
      bit cl;
      int xi;
      int xq;
      if (lock_off > 0) lock_off--;
      else if ($urandom_range(0, 199) == 0) lock_off = int'($urandom_range(1, 4));
      lk = (lock_off == 0);
      cl = ($urandom_range(0, 299) == 0);
      v  = ($urandom_range(0, 3) != 0);
      xi = rand_axis();
      xq = rand_axis();
      drive(v, xi, xq, lk, cl);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/evm_monitor.md
# evm_monitor

Link-quality monitor directly downstream of `rx_top`, in parallel with the constellation renderer's input.
- Slices each demodulated 16-QAM symbol to the nearest ideal point and emits the Gray-coded hard decision.
- Accumulates squared error-vector magnitude over fixed windows of 2^WIN_LOG2 locked symbols.
- Publishes a per-window mean EVM² and a 2-bit quality grade for LEDs and on-screen status.

## Interface
- DATA_W, 16: width of signed `demod_I`/`demod_Q` (matches `sample_t`).
- LVL_LOG2, 11: ideal inner amplitude LVL = 2^LVL_LOG2; ideal levels are ±LVL and ±3·LVL.
- WIN_LOG2, 10: window length is 2^WIN_LOG2 accepted symbols.
- MEAN_W, 2·LVL_LOG2+3: width of `evm_mean`.
- TH_GOOD, 40000; TH_FAIR, 160000; TH_POOR, 640000: thresholds on `evm_mean` used for `quality`.
- clk_dsp  in  1  DSP clock; all logic is in this domain.
- sys_rst_n  in  1  reset: asynchronous assert, active-low.
- clr  in  1  synchronous window restart.
- demod_I, demod_Q  in  DATA_W  signed demodulated symbol.
- demod_valid  in  1  symbol strobe, one cycle per symbol.
- demod_lock  in  1  Costas lock indicator.
- sym_idx  out  4  hard decision {gI[1:0], gQ[1:0]}.
- sym_idx_valid  out  1  one-cycle strobe qualifying `sym_idx`.
- evm_mean  out  MEAN_W  window mean of e_I²+e_Q².
- evm_valid  out  1  one-cycle strobe when a window completes.
- quality  out  2  3 = good, 2 = fair, 1 = poor, 0 = bad/unknown.
- win_abort  out  1  one-cycle pulse when a partial window is discarded.

## Operation
- Accept condition: `demod_valid` && `demod_lock` && !`clr`.
- Slicing, per axis, with x the axis sample:
  - x < −2·LVL gives −3, Gray code 00.
  - −2·LVL ≤ x < 0 gives −1, Gray code 01.
  - 0 ≤ x < 2·LVL gives +1, Gray code 11.
  - x ≥ 2·LVL gives +3, Gray code 10.
  - Boundary ties resolve upward.
- Error: e = x − ideal, clamped to ±(2·LVL−1). Each e² fits in 2·LVL_LOG2+2 bits; their sum fits in MEAN_W bits.
- Pipeline:
  - S1 registers slice and clamped errors.
  - S2 registers e_I²+e_Q².
  - S3 adds the result into the accumulator (MEAN_W+WIN_LOG2 bits, cannot overflow) and increments the symbol count.
- Window completion: the add of the 2^WIN_LOG2-th sample does all of the following in that same cycle:
  - loads `evm_mean` = (acc+e²) >> WIN_LOG2 (truncating);
  - pulses `evm_valid`;
  - updates `quality`;
  - clears the accumulator and count.
- Quality grading: mean < TH_GOOD gives 3; < TH_FAIR gives 2; < TH_POOR gives 1; otherwise 0.
- FSM:
  - IDLE: entered on reset. Moves to ACC when `demod_lock` = 1.
  - ACC: moves to IDLE when `demod_lock` = 0.
  - On ACC→IDLE: accumulator, count and in-flight S1/S2 contributions are discarded. `win_abort` pulses 1 cycle only if count ≠ 0 or any stage held a sample.
- `clr`: same flush as a lock loss, but without `win_abort`. Remains in ACC if locked.
- Held values: `evm_mean` and `quality` keep their last values through IDLE and `clr`.
- `sym_idx`: holds between strobes. Decisions are emitted only for accepted symbols.

## Timing
- Reset values: `sym_idx` = 0, `sym_idx_valid` = 0, `evm_mean` = 0, `evm_valid` = 0, `quality` = 0, `win_abort` = 0. FSM starts in IDLE, accumulator and count are 0.
- Latency:
  - `sym_idx_valid` is 1 cycle after the accepting edge.
  - `evm_valid` is 3 cycles after the last symbol of the window is accepted.
- Back-to-back: `demod_valid` may be high every cycle; full throughput, no stalls, no backpressure.
- Lock loss while the last sample is in S1/S2: the window is aborted. `evm_valid` is not asserted; `win_abort` pulses.
- Simultaneous events:
  - `clr` in the cycle the last sample is added: `clr` wins, no `evm_valid`.
  - `clr` together with `demod_valid`: that sample is not accepted.
- Reset mid-window: all state returns to reset values asynchronously; the next window starts from count 0.
- `quality` and `evm_mean` change only on the `evm_valid` edge.

## Test plan
Default parameters, except WIN_LOG2 = 4 (16-symbol window); `demod_lock` = 1 unless stated.
- Ideal point: 16× (I=2048, Q=−6144) -> `sym_idx` = 4'hC on each strobe 1 cycle later; `evm_valid` 3 cycles after the 16th symbol; `evm_mean` = 0; `quality` = 3.
- Small offset: 16× (I=2148, Q=2048) -> `sym_idx` = 4'hF; `evm_mean` = 10000; `quality` = 3.
- Clamp path: 16× (I=32767, Q=0) -> `sym_idx` = 4'hB; e_I clamped to 4095 (e_I² = 16769025), e_Q = −2048 (e_Q² = 4194304); `evm_mean` = 20963329; `quality` = 0.
- Slicer boundaries: I ∈ {4096, 4095, 0, −1, −4096, −4097} with Q=2048 -> gI = 10, 11, 11, 01, 01, 00 respectively.
- Lock loss: 7 symbols, then `demod_lock` = 0 -> one `win_abort` pulse, no `evm_valid`, `evm_mean`/`quality` unchanged. Relock, 16× (I=2248, Q=2048) -> `evm_mean` = 40000 from the new window only; `quality` = 2.
- `clr` and reset: `clr` asserted in the cycle the 16th sample is added -> no `evm_valid`, no `win_abort`, count restarts at 0. `sys_rst_n` low mid-window -> all outputs 0 immediately.
